circuito_projeto_uc: RTL and testbench

//  Control unit sequencing circuito_projeto_fd: measure (3 sensors), classify, act on valve and buzzers, send 4-char ASCII report, wait 1 s, repeat.

---
 rtl/circuito_projeto_pkg.sv | 26 ++
 rtl/circuito_projeto_uc.sv | 121 ++++++++++++
 tb/tb_circuito_projeto_uc.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/circuito_projeto_pkg.sv
// Shared definitions for the circuito_projeto control unit: state codes and
// measurement class codes (the class codes match classificador_medida).
package circuito_projeto_pkg;

  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    MEDE       = 4'd2,
    ESP_MED    = 4'd3,
    CLASSIFICA = 4'd4,
    ESP_CLASS  = 4'd5,
    ATUA       = 4'd6,
    TRANSMITE  = 4'd7,
    ESP_TX     = 4'd8,
    PROX       = 4'd9,
    INTERVALO  = 4'd10,
    FALHA      = 4'd11,
    ERRO       = 4'd12
  } estado_t;

  localparam logic [2:0] CLASSE_NORMAL  = 3'b000;
  localparam logic [2:0] CLASSE_BAIXO   = 3'b001;
  localparam logic [2:0] CLASSE_ALTO    = 3'b010;
  localparam logic [2:0] CLASSE_CRITICO = 3'b011;

endpackage

// File: rtl/circuito_projeto_uc.sv
// Control unit for circuito_projeto_fd: measure, classify, act on valve/buzzers,
// send a 4-char report, wait 1 s, repeat. Owns the 2 s timeout and retry policy.
module circuito_projeto_uc
  import circuito_projeto_pkg::*;
#(
  parameter int MAX_RETRY = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       fim_medida,
  input  logic       fim_classificacao,
  input  logic [2:0] medida_classificacao,
  input  logic       descartar_medida,
  input  logic       fim_carater,
  input  logic       fim_mensagem,
  input  logic       fim_1s,
  input  logic       fim_2s,
  output logic       zera,
  output logic       mensurar,
  output logic       analisa_medida,
  output logic       envia,
  output logic       muda,
  output logic       conta_1s,
  output logic       conta_2s,
  output logic       liga_buzzer_alta,
  output logic       liga_buzzer_baixa,
  output logic       desliga_buzzers,
  output logic       abre_valvula_auto,
  output logic       fecha_valvula_auto,
  output logic [3:0] db_estado
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  estado_t         estado, prox;
  logic [RW-1:0]   retry, retry_inc;
  logic [2:0]      classe;
  logic            ultimo;
  logic            erro_entrada;
  logic            excede;

  // Saturating increment; the FALHA decision uses the post-increment count.
  assign retry_inc = (retry == RW'(MAX_RETRY)) ? retry : retry + 1'b1;
  assign excede    = (int'(retry_inc) >= MAX_RETRY);
  assign db_estado = estado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= INICIAL;
      retry        <= '0;
      classe       <= CLASSE_NORMAL;
      ultimo       <= 1'b0;
      erro_entrada <= 1'b0;
    end else begin
      estado       <= prox;
      erro_entrada <= (prox == ERRO) && (estado != ERRO);
      if (estado == ESP_CLASS && fim_classificacao && !descartar_medida) begin
        classe <= medida_classificacao;
        retry  <= '0;
      end
      if (estado == ESP_TX && fim_carater) ultimo <= fim_mensagem;
      if (estado == FALHA) retry <= retry_inc;
      if (estado == ERRO && !ligar) retry <= '0;
    end
  end

  always_comb begin
    prox               = estado;
    zera               = 1'b0;
    mensurar           = 1'b0;
    analisa_medida     = 1'b0;
    envia              = 1'b0;
    muda               = 1'b0;
    conta_1s           = 1'b0;
    conta_2s           = 1'b0;
    liga_buzzer_alta   = 1'b0;
    liga_buzzer_baixa  = 1'b0;
    desliga_buzzers    = 1'b0;
    abre_valvula_auto  = 1'b0;
    fecha_valvula_auto = 1'b0;
    case (estado)
      INICIAL:    if (ligar) prox = PREPARA;
      PREPARA:    begin zera = 1'b1; prox = MEDE; end
      MEDE:       begin mensurar = 1'b1; prox = ESP_MED; end
      ESP_MED: begin
        conta_2s = 1'b1;
        if (fim_medida)  prox = CLASSIFICA;
        else if (fim_2s) prox = FALHA;
      end
      CLASSIFICA: begin analisa_medida = 1'b1; prox = ESP_CLASS; end
      ESP_CLASS:
        if (fim_classificacao) prox = descartar_medida ? FALHA : ATUA;
      ATUA: begin
        prox = TRANSMITE;
        // Any code outside the defined set is treated as critical.
        case (classe)
          CLASSE_NORMAL: desliga_buzzers = 1'b1;
          CLASSE_BAIXO:  begin abre_valvula_auto = 1'b1; liga_buzzer_baixa = 1'b1; end
          CLASSE_ALTO:   begin fecha_valvula_auto = 1'b1; desliga_buzzers = 1'b1; end
          default:       begin fecha_valvula_auto = 1'b1; liga_buzzer_alta = 1'b1; end
        endcase
      end
      TRANSMITE:  begin envia = 1'b1; prox = ESP_TX; end
      ESP_TX:     if (fim_carater) prox = PROX;
      PROX:       begin muda = 1'b1; prox = ultimo ? INTERVALO : TRANSMITE; end
      INTERVALO: begin
        conta_1s = 1'b1;
        if (fim_1s) prox = ligar ? PREPARA : INICIAL;
      end
      FALHA:      prox = excede ? ERRO : INTERVALO;
      ERRO: begin
        liga_buzzer_alta   = erro_entrada;
        fecha_valvula_auto = erro_entrada;
        if (!ligar) prox = INICIAL;
      end
      default:    prox = INICIAL;
    endcase
  end

endmodule

// File: tb/tb_circuito_projeto_uc.sv
// Bench for circuito_projeto_uc: table-driven normal cycle plus hand-written
// sequences for timeouts, discards, unknown class codes and async reset.
module tb_circuito_projeto_uc;
  import circuito_projeto_pkg::*;

  // Output bit positions in the packed out vector below.
  localparam logic [11:0] O_NONE  = 12'h000;
  localparam logic [11:0] O_ZERA  = 12'h800;
  localparam logic [11:0] O_MENS  = 12'h400;
  localparam logic [11:0] O_ANAL  = 12'h200;
  localparam logic [11:0] O_ENVIA = 12'h100;
  localparam logic [11:0] O_MUDA  = 12'h080;
  localparam logic [11:0] O_C1    = 12'h040;
  localparam logic [11:0] O_C2    = 12'h020;
  localparam logic [11:0] O_LBA   = 12'h010;
  localparam logic [11:0] O_LBB   = 12'h008;
  localparam logic [11:0] O_DESL  = 12'h004;
  localparam logic [11:0] O_ABRE  = 12'h002;
  localparam logic [11:0] O_FECHA = 12'h001;

  typedef struct packed {
    logic       ligar;
    logic       fim_medida;
    logic       fim_classificacao;
    logic [2:0] cls;
    logic       descartar;
    logic       fim_carater;
    logic       fim_mensagem;
    logic       fim_1s;
    logic       fim_2s;
  } in_t;

  typedef struct {
    in_t         in;
    estado_t     st;
    logic [11:0] out;
    string       name;
  } vec_t;

  logic       clock, reset;
  logic       ligar, fim_medida, fim_classificacao, descartar_medida;
  logic [2:0] medida_classificacao;
  logic       fim_carater, fim_mensagem, fim_1s, fim_2s;
  logic       zera, mensurar, analisa_medida, envia, muda, conta_1s, conta_2s;
  logic       liga_buzzer_alta, liga_buzzer_baixa, desliga_buzzers;
  logic       abre_valvula_auto, fecha_valvula_auto;
  logic [3:0] db_estado;
  logic [11:0] outs;

  int checks = 0;
  int fails  = 0;
  int n_envia = 0;
  int n_muda  = 0;
  vec_t tbl[$];

  circuito_projeto_uc #(.MAX_RETRY(3)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .fim_medida(fim_medida),
    .fim_classificacao(fim_classificacao), .medida_classificacao(medida_classificacao),
    .descartar_medida(descartar_medida), .fim_carater(fim_carater),
    .fim_mensagem(fim_mensagem), .fim_1s(fim_1s), .fim_2s(fim_2s),
    .zera(zera), .mensurar(mensurar), .analisa_medida(analisa_medida),
    .envia(envia), .muda(muda), .conta_1s(conta_1s), .conta_2s(conta_2s),
    .liga_buzzer_alta(liga_buzzer_alta), .liga_buzzer_baixa(liga_buzzer_baixa),
    .desliga_buzzers(desliga_buzzers), .abre_valvula_auto(abre_valvula_auto),
    .fecha_valvula_auto(fecha_valvula_auto), .db_estado(db_estado)
  );

  assign outs = {zera, mensurar, analisa_medida, envia, muda, conta_1s, conta_2s,
                 liga_buzzer_alta, liga_buzzer_baixa, desliga_buzzers,
                 abre_valvula_auto, fecha_valvula_auto};

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (envia) n_envia++;
    if (muda)  n_muda++;
  end

  function automatic in_t mk(input logic l, input logic fm, input logic fc,
                             input logic [2:0] c, input logic d, input logic fcar,
                             input logic fmsg, input logic f1, input logic f2);
    in_t r;
    r = '{ligar: l, fim_medida: fm, fim_classificacao: fc, cls: c, descartar: d,
          fim_carater: fcar, fim_mensagem: fmsg, fim_1s: f1, fim_2s: f2};
    return r;
  endfunction

  function automatic in_t lv(input logic l);
    return mk(l, 0, 0, 3'b000, 0, 0, 0, 0, 0);
  endfunction

  task automatic add(input in_t i, input estado_t st, input logic [11:0] o, input string nm);
    vec_t v;
    v.in = i; v.st = st; v.out = o; v.name = nm;
    tbl.push_back(v);
  endtask

  // Driver
  task automatic drive(input in_t i);
    ligar = i.ligar; fim_medida = i.fim_medida; fim_classificacao = i.fim_classificacao;
    medida_classificacao = i.cls; descartar_medida = i.descartar;
    fim_carater = i.fim_carater; fim_mensagem = i.fim_mensagem;
    fim_1s = i.fim_1s; fim_2s = i.fim_2s;
  endtask

  // Scoreboard checks
  task automatic check(input estado_t st, input logic [11:0] o, input string nm);
    checks++;
    if (db_estado !== 4'(st)) begin
      fails++;
      $display("FAIL %s state: got %0d expected %0d", nm, db_estado, 4'(st));
    end
    checks++;
    if (outs !== o) begin
      fails++;
      $display("FAIL %s outputs: got %03h expected %03h", nm, outs, o);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step(input in_t i, input estado_t st, input logic [11:0] o, input string nm);
    drive(i);
    @(posedge clock);
    #1;
    check(st, o, nm);
  endtask

  // From TRANSMITE: four characters, the last one flagged by fim_mensagem.
  task automatic send_msg(input logic l);
    for (int c = 0; c < 4; c++) begin
      step(lv(l), ESP_TX, O_NONE, "esp_tx");
      step(mk(l, 0, 0, 3'b000, 0, 1, (c == 3), 0, 0), PROX, O_MUDA, "prox");
      if (c == 3) step(lv(l), INTERVALO, O_C1, "intervalo");
      else        step(lv(l), TRANSMITE, O_ENVIA, "transmite");
    end
  endtask

  // From PREPARA: one successful cycle; ligar is held at l after MEDE.
  task automatic full_cycle(input logic [2:0] cls, input logic [11:0] act,
                            input logic both, input logic l, input string nm);
    int be, bm;
    be = n_envia; bm = n_muda;
    step(lv(1), MEDE, O_MENS, "mede");
    step(lv(l), ESP_MED, O_C2, "esp_med");
    step(mk(l, 1, 0, 3'b000, 0, 0, 0, 0, both), CLASSIFICA, O_ANAL, "classifica");
    step(lv(l), ESP_CLASS, O_NONE, "esp_class");
    step(mk(l, 0, 1, cls, 0, 0, 0, 0, 0), ATUA, act, nm);
    step(lv(l), TRANSMITE, O_ENVIA, "atua_one_cycle");
    send_msg(l);
    step(mk(l, 0, 0, 3'b000, 0, 0, 0, 1, 0), l ? PREPARA : INICIAL,
         l ? O_ZERA : O_NONE, "fim_intervalo");
    check_int({nm, "_envia_count"}, n_envia - be, 4);
    check_int({nm, "_muda_count"},  n_muda - bm, 4);
  endtask

  // From PREPARA: measurement times out.
  task automatic timeout_try(input logic last);
    step(lv(1), MEDE, O_MENS, "to_mede");
    step(lv(1), ESP_MED, O_C2, "to_esp_med");
    step(mk(1, 0, 0, 3'b000, 0, 0, 0, 0, 1), FALHA, O_NONE, "to_falha");
    if (last) begin
      step(lv(1), ERRO, O_LBA | O_FECHA, "erro_entry");
    end else begin
      step(lv(1), INTERVALO, O_C1, "to_intervalo");
      step(mk(1, 0, 0, 3'b000, 0, 0, 0, 1, 0), PREPARA, O_ZERA, "to_prepara");
    end
  endtask

  // From PREPARA: classifier reports disagreeing sensors.
  task automatic discard_try();
    step(lv(1), MEDE, O_MENS, "ds_mede");
    step(lv(1), ESP_MED, O_C2, "ds_esp_med");
    step(mk(1, 1, 0, 3'b000, 0, 0, 0, 0, 0), CLASSIFICA, O_ANAL, "ds_classifica");
    step(lv(1), ESP_CLASS, O_NONE, "ds_esp_class");
    step(mk(1, 0, 1, 3'b011, 1, 0, 0, 0, 0), FALHA, O_NONE, "ds_falha");
    step(lv(1), INTERVALO, O_C1, "ds_intervalo");
    step(mk(1, 0, 0, 3'b000, 0, 0, 0, 1, 0), PREPARA, O_ZERA, "ds_prepara");
  endtask

  initial begin
    int be;
    reset = 1'b1;
    drive(lv(0));
    @(posedge clock);
    @(posedge clock);
    #1;
    check(INICIAL, O_NONE, "reset_state");
    reset = 1'b0;

    // Vector table: BAIXO cycle with fim_medida after 10 cycles in ESP_MED.
    be = n_envia;
    add(lv(1), PREPARA, O_ZERA, "prepara");
    add(lv(1), MEDE, O_MENS, "mede");
    add(lv(1), ESP_MED, O_C2, "esp_med");
    for (int k = 0; k < 9; k++) add(lv(1), ESP_MED, O_C2, "esp_med_wait");
    add(mk(1, 1, 0, 3'b000, 0, 0, 0, 0, 0), CLASSIFICA, O_ANAL, "classifica");
    add(lv(1), ESP_CLASS, O_NONE, "esp_class");
    add(lv(1), ESP_CLASS, O_NONE, "esp_class_wait");
    add(mk(1, 0, 1, CLASSE_BAIXO, 0, 0, 0, 0, 0), ATUA, O_ABRE | O_LBB, "atua_baixo");
    add(lv(1), TRANSMITE, O_ENVIA, "transmite");
    for (int c = 0; c < 4; c++) begin
      add(lv(1), ESP_TX, O_NONE, "esp_tx");
      add(mk(1, 0, 0, 3'b000, 0, 1, (c == 3), 0, 0), PROX, O_MUDA, "prox");
      if (c == 3) add(lv(1), INTERVALO, O_C1, "intervalo");
      else        add(lv(1), TRANSMITE, O_ENVIA, "transmite");
    end
    add(lv(1), INTERVALO, O_C1, "intervalo_wait");
    add(mk(1, 0, 0, 3'b000, 0, 0, 0, 1, 0), PREPARA, O_ZERA, "restart");
    for (int i = 0; i < tbl.size(); i++) step(tbl[i].in, tbl[i].st, tbl[i].out, tbl[i].name);
    check_int("baixo_envia_count", n_envia - be, 4);

    // Critical class, with fim_medida and fim_2s together; then undefined code 3'b111.
    full_cycle(CLASSE_CRITICO, O_FECHA | O_LBA, 1'b1, 1'b1, "atua_critico");
    full_cycle(3'b111, O_FECHA | O_LBA, 1'b0, 1'b1, "atua_111");

    // Three consecutive timeouts end in ERRO with no report.
    be = n_envia;
    timeout_try(1'b0);
    timeout_try(1'b0);
    timeout_try(1'b1);
    step(lv(1), ERRO, O_NONE, "erro_hold1");
    step(lv(1), ERRO, O_NONE, "erro_hold2");
    check_int("erro_no_envia", n_envia - be, 0);
    step(lv(0), INICIAL, O_NONE, "erro_exit");
    step(lv(1), PREPARA, O_ZERA, "erro_restart");
    timeout_try(1'b0);
    full_cycle(CLASSE_ALTO, O_FECHA | O_DESL, 1'b0, 1'b1, "atua_alto");

    // Two discards, then a valid NORMAL with ligar dropped mid-cycle.
    discard_try();
    discard_try();
    full_cycle(CLASSE_NORMAL, O_DESL, 1'b0, 1'b0, "atua_normal");
    step(lv(1), PREPARA, O_ZERA, "normal_restart");
    timeout_try(1'b0);

    // Async reset while waiting on the transmitter.
    step(lv(1), MEDE, O_MENS, "rs_mede");
    step(lv(1), ESP_MED, O_C2, "rs_esp_med");
    step(mk(1, 1, 0, 3'b000, 0, 0, 0, 0, 0), CLASSIFICA, O_ANAL, "rs_classifica");
    step(lv(1), ESP_CLASS, O_NONE, "rs_esp_class");
    step(mk(1, 0, 1, CLASSE_NORMAL, 0, 0, 0, 0, 0), ATUA, O_DESL, "rs_atua");
    step(lv(1), TRANSMITE, O_ENVIA, "rs_transmite");
    step(lv(1), ESP_TX, O_NONE, "rs_esp_tx");
    step(mk(1, 0, 0, 3'b000, 0, 1, 0, 0, 0), PROX, O_MUDA, "rs_prox");
    step(lv(1), TRANSMITE, O_ENVIA, "rs_transmite2");
    step(lv(1), ESP_TX, O_NONE, "rs_esp_tx2");
    #2;
    reset = 1'b1;
    #1;
    check(INICIAL, O_NONE, "reset_async");
    @(posedge clock);
    #1;
    check(INICIAL, O_NONE, "reset_held");
    reset = 1'b0;
    step(lv(1), PREPARA, O_ZERA, "rs_restart");
    full_cycle(CLASSE_BAIXO, O_ABRE | O_LBB, 1'b0, 1'b0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
